// File: rtl/ines_loader.sv
// Purpose : iNES cartridge-image loader; parses the 16-byte header into mapper config and streams PRG/CHR payload into ROM.
// Latency : 1 cycle from an accepted byte to its write strobe/address/data; config registers update the cycle after header byte 15.
// Backpressure: s_ready is high in HDR/TRAINER/PRG/CHR (one byte per cycle), low in DONE/ERR and while rst is high.
//
// Ports: clk_cpu/rst (sync, active-high); s_data/s_valid/s_ready byte stream in;
//        mapper_id, mirrorv, prg_ram, chr_ram, prg_mask, chr_mask, prgram_mask static mapper config out;
//        prg_we/prg_wr_addr, chr_we/chr_wr_addr, wr_data ROM write port; cart_rst, done, err status.
// Build option: INES_TRAINER_EN -- when defined, a 512-byte trainer is skipped; otherwise a trainer flag is error 5.

module ines_loader #(
    parameter int PRG_ROM_DEPTH = 17,
    parameter int CHR_ROM_DEPTH = 15,
    parameter int PRG_RAM_DEPTH = 13
) (
    input  logic                     clk_cpu,
    input  logic                     rst,
    input  logic [7:0]               s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [7:0]               mapper_id,
    output logic                     mirrorv,
    output logic                     prg_ram,
    output logic                     chr_ram,
    output logic [PRG_ROM_DEPTH-1:0] prg_mask,
    output logic [CHR_ROM_DEPTH-1:0] chr_mask,
    output logic [PRG_RAM_DEPTH-1:0] prgram_mask,
    output logic                     prg_we,
    output logic [PRG_ROM_DEPTH-1:0] prg_wr_addr,
    output logic                     chr_we,
    output logic [CHR_ROM_DEPTH-1:0] chr_wr_addr,
    output logic [7:0]               wr_data,
    output logic                     cart_rst,
    output logic                     done,
    output logic [2:0]               err
);

    typedef enum logic [2:0] {
        HDR,
`ifdef INES_TRAINER_EN
        TRAINER,
`endif
        PRG,
        CHR,
        DONE,
        ERR
    } state_t;

    // Largest legal size in header units (16 KiB PRG, 8 KiB CHR) for the configured ROM widths.
    localparam logic [8:0] PRG_MAX_UNITS = 9'(1 << (PRG_ROM_DEPTH - 14));
    localparam logic [8:0] CHR_MAX_UNITS = 9'(1 << (CHR_ROM_DEPTH - 13));

    state_t                   state;
    logic [3:0]               hdr_cnt;
    logic [7:0]               hdr4;
    logic [7:0]               hdr5;
    logic [3:0]               hdr6_hi;
    logic [2:0]               hdr6_lo;
    logic [3:0]               hdr7_hi;
    logic [PRG_ROM_DEPTH:0]   prg_cnt;
    logic [CHR_ROM_DEPTH:0]   chr_cnt;
`ifdef INES_TRAINER_EN
    logic [8:0]               trn_cnt;
`endif

    logic                     accept;
    logic [7:0]               magic_byte;
    logic                     prg_ok;
    logic                     chr_ok;
    logic                     map_ok;
    logic [7:0]               map_id_w;
    logic [2:0]               hdr_err;
    logic [PRG_ROM_DEPTH:0]   prg_total;
    logic [CHR_ROM_DEPTH:0]   chr_total;
    logic [PRG_ROM_DEPTH:0]   prg_nxt;
    logic [CHR_ROM_DEPTH:0]   chr_nxt;

    assign s_ready = !rst && (state == HDR || state == PRG || state == CHR
`ifdef INES_TRAINER_EN
                              || state == TRAINER
`endif
                              );
    assign accept  = s_valid && s_ready;

    // Payload sizes in bytes; counters are one bit wider so the largest image ends without wrapping.
    assign prg_total = (PRG_ROM_DEPTH+1)'({hdr4, 14'd0});
    assign chr_total = (CHR_ROM_DEPTH+1)'({hdr5, 13'd0});
    assign prg_nxt   = prg_cnt + (PRG_ROM_DEPTH+1)'(1);
    assign chr_nxt   = chr_cnt + (CHR_ROM_DEPTH+1)'(1);
    assign map_id_w  = {hdr7_hi, hdr6_hi};

    always_comb begin
        magic_byte = 8'h4E;
        case (hdr_cnt[1:0])
            2'd0:    magic_byte = 8'h4E;
            2'd1:    magic_byte = 8'h45;
            2'd2:    magic_byte = 8'h53;
            default: magic_byte = 8'h1A;
        endcase
    end

    // Sizes must be a power of two no larger than the ROM; CHR size 0 means CHR-RAM.
    always_comb begin
        prg_ok = (hdr4 != 8'd0) && ((hdr4 & (hdr4 - 8'd1)) == 8'd0) && ({1'b0, hdr4} <= PRG_MAX_UNITS);
        chr_ok = (hdr5 == 8'd0) ||
                 (((hdr5 & (hdr5 - 8'd1)) == 8'd0) && ({1'b0, hdr5} <= CHR_MAX_UNITS));
        map_ok = (map_id_w == 8'd0) || (map_id_w == 8'd2) || (map_id_w == 8'd3) || (map_id_w == 8'd7);
        hdr_err = 3'd0;
        if (!prg_ok)
            hdr_err = 3'd2;
        else if (!chr_ok)
            hdr_err = 3'd3;
        else if (!map_ok)
            hdr_err = 3'd4;
`ifndef INES_TRAINER_EN
        else if (hdr6_lo[2])
            hdr_err = 3'd5;
`endif
    end

    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            state       <= HDR;
            hdr_cnt     <= 4'd0;
            hdr4        <= 8'd0;
            hdr5        <= 8'd0;
            hdr6_hi     <= 4'd0;
            hdr6_lo     <= 3'd0;
            hdr7_hi     <= 4'd0;
            prg_cnt     <= '0;
            chr_cnt     <= '0;
`ifdef INES_TRAINER_EN
            trn_cnt     <= 9'd0;
`endif
            mapper_id   <= 8'd0;
            mirrorv     <= 1'b0;
            prg_ram     <= 1'b0;
            chr_ram     <= 1'b0;
            prg_mask    <= '0;
            chr_mask    <= '0;
            prgram_mask <= '0;
            prg_we      <= 1'b0;
            prg_wr_addr <= '0;
            chr_we      <= 1'b0;
            chr_wr_addr <= '0;
            wr_data     <= 8'd0;
            cart_rst    <= 1'b1;
            done        <= 1'b0;
            err         <= 3'd0;
        end else begin
            prg_we <= 1'b0;
            chr_we <= 1'b0;
            case (state)
                HDR: if (accept) begin
                    hdr_cnt <= hdr_cnt + 4'd1;
                    case (hdr_cnt)
                        4'd0, 4'd1, 4'd2, 4'd3: if (s_data != magic_byte) begin
                            err   <= 3'd1;
                            state <= ERR;
                        end
                        4'd4: hdr4 <= s_data;
                        4'd5: hdr5 <= s_data;
                        4'd6: begin
                            hdr6_hi <= s_data[7:4];
                            hdr6_lo <= s_data[2:0];
                        end
                        4'd7: hdr7_hi <= s_data[7:4];
                        4'd15: begin
                            if (hdr_err != 3'd0) begin
                                err   <= hdr_err;
                                state <= ERR;
                            end else begin
                                mapper_id   <= map_id_w;
                                mirrorv     <= hdr6_lo[0];
                                prg_ram     <= hdr6_lo[1];
                                chr_ram     <= (hdr5 == 8'd0);
                                prg_mask    <= prg_total[PRG_ROM_DEPTH-1:0] - PRG_ROM_DEPTH'(1);
                                chr_mask    <= (hdr5 == 8'd0) ? CHR_ROM_DEPTH'(13'h1FFF)
                                                              : chr_total[CHR_ROM_DEPTH-1:0] - CHR_ROM_DEPTH'(1);
                                prgram_mask <= '1;
`ifdef INES_TRAINER_EN
                                state       <= hdr6_lo[2] ? TRAINER : PRG;
`else
                                state       <= PRG;
`endif
                            end
                        end
                        default: ;
                    endcase
                end
`ifdef INES_TRAINER_EN
                TRAINER: if (accept) begin
                    trn_cnt <= trn_cnt + 9'd1;
                    if (trn_cnt == 9'd511)
                        state <= PRG;
                end
`endif
                PRG: if (accept) begin
                    prg_we      <= 1'b1;
                    prg_wr_addr <= prg_cnt[PRG_ROM_DEPTH-1:0];
                    wr_data     <= s_data;
                    prg_cnt     <= prg_nxt;
                    if (prg_nxt == prg_total) begin
                        if (chr_ram) begin
                            // Release the console in the same cycle as the final write.
                            state    <= DONE;
                            done     <= 1'b1;
                            cart_rst <= 1'b0;
                        end else begin
                            state <= CHR;
                        end
                    end
                end
                CHR: if (accept) begin
                    chr_we      <= 1'b1;
                    chr_wr_addr <= chr_cnt[CHR_ROM_DEPTH-1:0];
                    wr_data     <= s_data;
                    chr_cnt     <= chr_nxt;
                    if (chr_nxt == chr_total) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cart_rst <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ines_loader.sv
module tb_ines_loader;

    logic        clk_cpu = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  mapper_id;
    logic        mirrorv, prg_ram, chr_ram;
    logic [16:0] prg_mask;
    logic [14:0] chr_mask;
    logic [12:0] prgram_mask;
    logic        prg_we, chr_we;
    logic [16:0] prg_wr_addr;
    logic [14:0] chr_wr_addr;
    logic [7:0]  wr_data;
    logic        cart_rst, done;
    logic [2:0]  err;

    ines_loader dut (
        .clk_cpu(clk_cpu), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mapper_id(mapper_id), .mirrorv(mirrorv), .prg_ram(prg_ram), .chr_ram(chr_ram),
        .prg_mask(prg_mask), .chr_mask(chr_mask), .prgram_mask(prgram_mask),
        .prg_we(prg_we), .prg_wr_addr(prg_wr_addr), .chr_we(chr_we), .chr_wr_addr(chr_wr_addr),
        .wr_data(wr_data), .cart_rst(cart_rst), .done(done), .err(err)
    );

    always #5 clk_cpu = ~clk_cpu;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- image and expectation model ----------------
    logic [7:0] hdr_b [16];
    logic [7:0] magic [4] = '{8'h4E, 8'h45, 8'h53, 8'h1A};
    int  e_limit = 0, e_err = 0, e_tr = 0, e_prgb = 0, e_chrb = 0;
    bit  e_good = 0;
    logic [7:0] e_mapper = 0;
    bit  e_mirrorv = 0, e_prgram = 0, e_chrram = 0;
    int  e_prgmask = 0, e_chrmask = 0;

    function automatic logic [7:0] img_byte(input int idx);
        int v;
        if (idx < 16) return hdr_b[idx];
        v = (idx * 13) ^ (idx >>> 7) ^ 32'h5A;
        return v[7:0];
    endfunction

    // Derive what a loader must do with the current header purely from the format rules.
    function automatic void plan();
        logic [7:0] h4, h5, h6, h7, m;
        e_limit = 16; e_err = 0; e_tr = 0; e_good = 0; e_prgb = 0; e_chrb = 0;
        for (int i = 0; i < 4; i++)
            if (e_err == 0 && hdr_b[i] != magic[i]) begin
                e_err = 1;
                e_limit = i + 1;
            end
        h4 = hdr_b[4]; h5 = hdr_b[5]; h6 = hdr_b[6]; h7 = hdr_b[7];
        m = {h7[7:4], h6[7:4]};
        if (e_err == 0) begin
            if (!(h4 inside {8'd1, 8'd2, 8'd4, 8'd8}))            e_err = 2;
            else if (!(h5 inside {8'd0, 8'd1, 8'd2, 8'd4}))       e_err = 3;
            else if (!(m inside {8'd0, 8'd2, 8'd3, 8'd7}))        e_err = 4;
            else if (h6[2]) begin
`ifdef INES_TRAINER_EN
                e_tr = 512;
`else
                e_err = 5;
`endif
            end
        end
        if (e_err == 0) begin
            e_good    = 1;
            e_prgb    = int'(h4) * 16384;
            e_chrb    = int'(h5) * 8192;
            e_limit   = 16 + e_tr + e_prgb + e_chrb;
            e_mapper  = m;
            e_mirrorv = h6[0];
            e_prgram  = h6[1];
            e_chrram  = (h5 == 0);
            e_prgmask = e_prgb - 1;
            e_chrmask = (h5 == 0) ? 32'h1FFF : e_chrb - 1;
        end
    endfunction

    // Bytes accepted so far, advanced on every handshake the loader is entitled to take.
    int n_acc = 0;
    int acc_idx = 0;
    bit acc_edge = 0;
    always @(posedge clk_cpu) begin
        acc_edge = 0;
        if (rst)
            n_acc = 0;
        else if (s_valid && n_acc < e_limit) begin
            acc_idx  = n_acc;
            n_acc    = n_acc + 1;
            acc_edge = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 0;
    int n_prg_seen = 0, n_chr_seen = 0;
    logic [7:0] first_prg_dat = 0;
    bit last_done = 0, rise_we = 0;

    always @(negedge clk_cpu) begin
        if (chk_en) begin
            automatic bit fin = (n_acc == e_limit);
            automatic bit cfg = e_good && (n_acc >= 16);
            automatic int off;
            chk("s_ready",  32'(s_ready),  32'(!rst && n_acc < e_limit));
            chk("done",     32'(done),     32'(e_good && fin));
            chk("cart_rst", 32'(cart_rst), 32'(!(e_good && fin)));
            chk("err",      32'(err),      (!e_good && fin) ? e_err : 0);
            chk("mapper_id",   32'(mapper_id),   cfg ? 32'(e_mapper) : 0);
            chk("mirrorv",     32'(mirrorv),     cfg ? 32'(e_mirrorv) : 0);
            chk("prg_ram",     32'(prg_ram),     cfg ? 32'(e_prgram) : 0);
            chk("chr_ram",     32'(chr_ram),     cfg ? 32'(e_chrram) : 0);
            chk("prg_mask",    32'(prg_mask),    cfg ? e_prgmask : 0);
            chk("chr_mask",    32'(chr_mask),    cfg ? e_chrmask : 0);
            chk("prgram_mask", 32'(prgram_mask), cfg ? 32'h1FFF : 0);
            if (acc_edge && e_good && acc_idx >= 16 + e_tr) begin
                off = acc_idx - 16 - e_tr;
                if (off < e_prgb) begin
                    chk("prg_we", 32'(prg_we), 1);
                    chk("chr_we", 32'(chr_we), 0);
                    chk("prg_wr_addr", 32'(prg_wr_addr), off);
                end else begin
                    chk("prg_we", 32'(prg_we), 0);
                    chk("chr_we", 32'(chr_we), 1);
                    chk("chr_wr_addr", 32'(chr_wr_addr), off - e_prgb);
                end
                chk("wr_data", 32'(wr_data), 32'(img_byte(acc_idx)));
            end else begin
                chk("prg_we", 32'(prg_we), 0);
                chk("chr_we", 32'(chr_we), 0);
            end
            if (prg_we === 1'b1) begin
                if (n_prg_seen == 0) first_prg_dat = wr_data;
                n_prg_seen++;
            end
            if (chr_we === 1'b1) n_chr_seen++;
            if (done === 1'b1 && !last_done) rise_we = (prg_we === 1'b1) || (chr_we === 1'b1);
            last_done = (done === 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk_reset_vals();
        chk("rst s_ready", 32'(s_ready), 0);
        chk("rst mapper_id", 32'(mapper_id), 0);
        chk("rst cfg_bits", 32'({mirrorv, prg_ram, chr_ram}), 0);
        chk("rst prg_mask", 32'(prg_mask), 0);
        chk("rst chr_mask", 32'(chr_mask), 0);
        chk("rst prgram_mask", 32'(prgram_mask), 0);
        chk("rst we", 32'({prg_we, chr_we}), 0);
        chk("rst prg_wr_addr", 32'(prg_wr_addr), 0);
        chk("rst chr_wr_addr", 32'(chr_wr_addr), 0);
        chk("rst wr_data", 32'(wr_data), 0);
        chk("rst cart_rst", 32'(cart_rst), 1);
        chk("rst done", 32'(done), 0);
        chk("rst err", 32'(err), 0);
    endtask

    task automatic run_image(input logic [7:0] h4, input logic [7:0] h5, input logic [7:0] h6,
                             input logic [7:0] h7, input logic [7:0] b2, input int gap_from,
                             input int abort_at);
        int cyc, budget;
        rst = 1'b1;
        @(posedge clk_cpu); #1;
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) hdr_b[i] = magic[i];
        hdr_b[2] = b2;
        hdr_b[4] = h4; hdr_b[5] = h5; hdr_b[6] = h6; hdr_b[7] = h7;
        for (int i = 8; i < 16; i++) hdr_b[i] = 8'(8'hC0 + i);
        plan();
        n_prg_seen = 0; n_chr_seen = 0; rise_we = 0; first_prg_dat = 0;
        chk_en = 1;
        chk_reset_vals();
        @(posedge clk_cpu); #1;
        rst = 1'b0;
        budget = 2 * e_limit + 200;
        cyc = 0;
        while (n_acc < e_limit && n_acc < abort_at && cyc < budget) begin
            if (n_acc >= gap_from && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
            end else begin
                s_valid = 1'b1;
                s_data  = img_byte(n_acc);
            end
            @(posedge clk_cpu); #1;
            cyc++;
        end
        chk("timeout", 32'(cyc >= budget), 0);
        if (n_acc < abort_at) begin
            // Keep offering bytes after completion; none may be taken.
            s_valid = 1'b1;
            s_data  = 8'hEE;
            repeat (4) @(posedge clk_cpu);
            #1;
            s_valid = 1'b0;
            @(posedge clk_cpu); #1;
        end
    endtask

    initial begin
        // NROM 32K/8K, gaps only during CHR.
        run_image(8'd2, 8'd1, 8'h01, 8'h00, 8'h53, 16 + 32768, 1 << 30);
        chk("nrom prg_mask", 32'(prg_mask), 32'h07FFF);
        chk("nrom chr_mask", 32'(chr_mask), 32'h1FFF);
        chk("nrom mirrorv", 32'(mirrorv), 1);
        chk("nrom mapper_id", 32'(mapper_id), 0);
        chk("nrom prg writes", n_prg_seen, 32768);
        chk("nrom chr writes", n_chr_seen, 8192);
        chk("nrom done with last we", 32'(rise_we), 1);
        chk("nrom done/cart_rst", 32'({done, cart_rst}), 32'b10);

        // UNROM 128K CHR-RAM: check config then reset mid-PRG.
        run_image(8'd8, 8'd0, 8'h20, 8'h00, 8'h53, 300, 16 + 1000);
        chk("unrom mapper_id", 32'(mapper_id), 2);
        chk("unrom chr_ram", 32'(chr_ram), 1);
        chk("unrom prg_mask", 32'(prg_mask), 32'h1FFFF);
        chk("unrom chr_mask", 32'(chr_mask), 32'h1FFF);

        // Fresh CHR-RAM image after the abort: PRG only, done on last PRG write.
        run_image(8'd1, 8'd0, 8'h22, 8'h00, 8'h53, 16, 1 << 30);
        chk("chrram prg_mask", 32'(prg_mask), 32'h03FFF);
        chk("chrram prg writes", n_prg_seen, 16384);
        chk("chrram chr writes", n_chr_seen, 0);
        chk("chrram done with last we", 32'(rise_we), 1);

        // CNROM header with 16K CHR, aborted early.
        run_image(8'd1, 8'd2, 8'h30, 8'h00, 8'h53, 1 << 30, 40);
        chk("cnrom mapper_id", 32'(mapper_id), 3);
        chk("cnrom chr_mask", 32'(chr_mask), 32'h3FFF);

        // Error cases.
        run_image(8'd2, 8'd1, 8'h01, 8'h00, 8'h54, 1 << 30, 1 << 30);
        chk("magic err", 32'(err), 1);
        chk("magic s_ready", 32'(s_ready), 0);
        chk("magic cart_rst", 32'(cart_rst), 1);
        chk("magic writes", n_prg_seen + n_chr_seen, 0);
        run_image(8'd3, 8'd1, 8'h00, 8'h00, 8'h53, 1 << 30, 1 << 30);
        chk("hdr4=3 err", 32'(err), 2);
        run_image(8'd2, 8'd8, 8'h00, 8'h00, 8'h53, 1 << 30, 1 << 30);
        chk("hdr5=8 err", 32'(err), 3);
        run_image(8'd2, 8'd1, 8'h40, 8'h00, 8'h53, 1 << 30, 1 << 30);
        chk("mapper4 err", 32'(err), 4);
        run_image(8'd2, 8'd1, 8'h00, 8'h10, 8'h53, 1 << 30, 1 << 30);
        chk("mapper16 err", 32'(err), 4);

        // Trainer flag.
        run_image(8'd1, 8'd0, 8'h04, 8'h00, 8'h53, 1 << 30, 1 << 30);
`ifdef INES_TRAINER_EN
        chk("trainer done", 32'(done), 1);
        chk("trainer first prg byte", 32'(first_prg_dat), 32'(img_byte(528)));
`else
        chk("trainer err", 32'(err), 5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ines_loader.md
# ines_loader

Cartridge-image loader and mapper configurator. Accepts an iNES image as a byte stream and parses the 16-byte header into the static configuration consumed by the cartridge mapper: mapper id, mirroring, CHR-RAM/PRG-RAM flags and address masks. Writes the PRG and CHR payloads into the cartridge ROM memories, and holds the console in reset until the image is complete. Sits between the host/SD byte source and the mapper and ROM memories.

## Interface
- PRG_ROM_DEPTH, 17, PRG ROM address width (bytes).
- CHR_ROM_DEPTH, 15, CHR ROM/RAM address width (bytes).
- PRG_RAM_DEPTH, 13, PRG RAM address width (bytes).

Ports:
- clk_cpu  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous and active-high.
- s_data  in  8  image byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts a byte; a transfer is s_valid && s_ready.
- mapper_id  out  8  {hdr7[7:4], hdr6[7:4]}.
- mirrorv  out  1  hdr6[0] (1 = vertical).
- prg_ram  out  1  hdr6[1].
- chr_ram  out  1  1 when hdr5 == 0.
- prg_mask  out  PRG_ROM_DEPTH  (hdr4 × 16 KiB) − 1.
- chr_mask  out  CHR_ROM_DEPTH  (hdr5 × 8 KiB) − 1; 13'h1FFF zero-extended when chr_ram.
- prgram_mask  out  PRG_RAM_DEPTH  all ones.
- prg_we  out  1  PRG ROM write strobe.
- prg_wr_addr  out  PRG_ROM_DEPTH  PRG write address.
- chr_we  out  1  CHR write strobe.
- chr_wr_addr  out  CHR_ROM_DEPTH  CHR write address.
- wr_data  out  8  write data, shared by prg_we and chr_we.
- cart_rst  out  1  console reset request.
- done  out  1  image loaded, configuration valid.
- err  out  3  error code: 0 none, 1 bad magic, 2 bad PRG size, 3 bad CHR size, 4 unsupported mapper, 5 trainer not supported.

## Operation
- States: HDR, TRAINER, PRG, CHR, DONE, ERR. Reset enters HDR.
- Reset values:
  - All configuration outputs 0.
  - prg_we/chr_we 0; both write addresses 0; wr_data 0.
  - cart_rst 1; done 0; err 0; s_ready 0.
- s_ready:
  - 1 in HDR, TRAINER, PRG and CHR.
  - 0 in DONE and ERR, and in the cycle rst is high.
- HDR:
  - A 4-bit byte counter indexes accepted bytes.
  - Bytes 0–3 must be 4E 45 53 1A. On a mismatch, err=1 and the next state is ERR.
  - Bytes 4–7 are captured; bytes 8–15 are discarded.
  - On acceptance of byte 15, checks run in priority order:
    - hdr4 not in {1,2,4,…,2^(PRG_ROM_DEPTH−14)} → err=2.
    - hdr5 not in {0,1,2,4,…,2^(CHR_ROM_DEPTH−13)} → err=3.
    - mapper_id not in {0,2,3,7} → err=4.
    - Trainer check (see Configuration).
  - Any failure → ERR. Otherwise the configuration outputs are registered, and the next state is TRAINER if hdr6[2] is set, else PRG.
- TRAINER: discard exactly 512 bytes, then go to PRG.
- PRG:
  - Each accepted byte produces prg_we=1 for one cycle, with prg_wr_addr = running count and wr_data = that byte.
  - After hdr4×16384 bytes, go to CHR if hdr5≠0, else DONE.
- CHR: same as PRG but on the chr_* outputs, for hdr5×8192 bytes, then go to DONE.
- Byte counters are PRG_ROM_DEPTH+1 and CHR_ROM_DEPTH+1 bits wide, so the maximum size completes without wrap. Write addresses are the low bits of the counters.
- DONE: done=1 and cart_rst=0. Held until rst.
- ERR: cart_rst=1, done=0, err held. Sticky until rst.
- s_valid low stalls any state indefinitely, with no timeout.
- Bytes presented in DONE/ERR are not accepted.
- rst mid-load aborts immediately. All outputs return to reset values, and the next image restarts at header byte 0.

## Timing
- Write latency: 1 cycle. A byte accepted in cycle N produces its strobe, address and data in cycle N+1.
- Throughput: one byte per cycle sustained.
- Configuration outputs change once, in the cycle after header byte 15 is accepted. They are stable from then until rst.
- err is set in the cycle after the offending byte is accepted.
- cart_rst and done:
  - Last payload byte (final PRG byte when chr_ram, else final CHR byte) accepted in cycle N.
  - Its write strobe is in N+1.
  - cart_rst falls and done rises in N+1.
  - So the strobe, cart_rst falling and done rising all coincide in N+1; the mapper never sees cart_rst low before the final write.
- The transition out of a state happens on the final accepted byte. There is no bubble cycle: s_ready stays 1 across HDR→PRG→CHR.

## Configuration
- INES_TRAINER_EN defined: when hdr6[2] is set, the 512-byte trainer is skipped via the TRAINER state.
- INES_TRAINER_EN undefined:
  - When hdr6[2] is set, err=5 and the block enters ERR.
  - The TRAINER state and its counter are not compiled.

## Test plan
- NROM 32 KiB/8 KiB (hdr4=2, hdr5=1, hdr6=01, hdr7=00), s_valid held high → prg_mask=17'h07FFF, chr_mask=15'h1FFF, mirrorv=1, mapper_id=0. 32768 prg_we then 8192 chr_we. done and cart_rst change in the same cycle as the last chr_we.
- UNROM 128 KiB, CHR-RAM (hdr4=8, hdr5=0, hdr6=20) → mapper_id=2, chr_ram=1, prg_mask=17'h1FFFF, chr_mask=15'h1FFF. No chr_we; done after 131072 PRG bytes.
- Magic error (byte 2 = 0x54) → err=1 and s_ready=0 from the next cycle, cart_rst=1, no write strobes; persists until rst.
- Header checks:
  - hdr4=3 → err=2.
  - hdr5=8 with CHR_ROM_DEPTH=15 → err=3.
  - hdr6=40 (mapper 4) → err=4.
- Random s_valid gaps during CHR, plus rst asserted mid-PRG → writes stay in address order. After rst, all outputs return to reset values and a fresh image loads correctly.
- hdr6[2]=1:
  - With INES_TRAINER_EN: 512 bytes are skipped, and the first prg_we carries image byte 528.
  - Without INES_TRAINER_EN: err=5.
